// File: rtl/hamming_pkg.sv
// Shared widths, FSM state encoding and packed-bus slice helpers for the
// Hamming codec arbiter.
package hamming_pkg;

  localparam int DATA_W  = 16;
  localparam int CODE_W  = 21;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Buses are zero-padded to MAX_REQ slices so one helper serves any NUM_REQ.
  function automatic logic [DATA_W-1:0] slice_data(
    input logic [MAX_REQ*DATA_W-1:0] bus,
    input int unsigned               idx
  );
    return bus[idx*DATA_W +: DATA_W];
  endfunction

  function automatic logic [CODE_W-1:0] slice_error(
    input logic [MAX_REQ*CODE_W-1:0] bus,
    input int unsigned               idx
  );
    return bus[idx*CODE_W +: CODE_W];
  endfunction

endpackage

// File: rtl/hamming_codec_arbiter_rr_arbiter.sv
// Round-robin grant: combinational search from the pointer upward, with the
// pointer moving past the served requester on an advance strobe.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [IDX_W-1:0]   adv_idx,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand [NUM_REQ];

  // cand[gi] is the requester index gi positions after the pointer, wrapped.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum      = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                        IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
    end
  endgenerate

  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant = cand[k];
        any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (adv_idx == IDX_W'(NUM_REQ - 1)) ? '0 : adv_idx + 1'b1;
    end
  end

endmodule

// File: rtl/hamming_codec_arbiter.sv
// Shares one Hamming(21,16) codec between NUM_REQ requesters: round-robin
// grant, single outstanding transaction, timeout and spurious-answer tracking.
module hamming_codec_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = hamming_pkg::DATA_W,
  parameter int CODE_W  = hamming_pkg::CODE_W,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  input  logic [NUM_REQ*CODE_W-1:0] reqError,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic [NUM_REQ-1:0]        respValid,
  input  logic [NUM_REQ-1:0]        respReady,
  output logic [DATA_W-1:0]         respData,
  output logic                      respMismatch,
  output logic                      respTimeout,
  output logic [DATA_W-1:0]         cdcData,
  output logic [CODE_W-1:0]         cdcError,
  output logic                      cdcValid,
  output logic                      cdcReady,
  input  logic                      cdcDecValid,
  input  logic [DATA_W-1:0]         cdcDecData,
  output logic [7:0]                spuriousCnt
);

  import hamming_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t                              state;
  logic [IDX_W-1:0]                    grant;
  logic [IDX_W-1:0]                    grant_reg;
  logic                                any;
  logic                                advance;
  logic [CNT_W-1:0]                    cnt;
  logic [MAX_REQ*hamming_pkg::DATA_W-1:0] data_bus;
  logic [MAX_REQ*hamming_pkg::CODE_W-1:0] error_bus;
  logic [NUM_REQ-1:0]                  grant_onehot;

  assign data_bus     = (MAX_REQ*hamming_pkg::DATA_W)'(reqData);
  assign error_bus    = (MAX_REQ*hamming_pkg::CODE_W)'(reqError);
  assign grant_onehot = (NUM_REQ)'(1) << grant_reg;
  assign advance      = (state == RESP) && respReady[grant_reg];
  assign reqReady     = (state == IDLE && any) ? ((NUM_REQ)'(1) << grant) : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (reqValid),
    .advance (advance),
    .adv_idx (grant_reg),
    .grant   (grant),
    .any     (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant_reg    <= '0;
      cnt          <= '0;
      respValid    <= '0;
      respData     <= '0;
      respMismatch <= 1'b0;
      respTimeout  <= 1'b0;
      cdcData      <= '0;
      cdcError     <= '0;
      cdcValid     <= 1'b0;
      cdcReady     <= 1'b0;
      spuriousCnt  <= '0;
    end else begin
      cdcValid <= 1'b0;
      if (cdcDecValid && state != WAIT && spuriousCnt != 8'hFF) begin
        spuriousCnt <= spuriousCnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (any) begin
            grant_reg <= grant;
            cdcData   <= slice_data(data_bus, 32'(grant));
            cdcError  <= slice_error(error_bus, 32'(grant));
            cdcValid  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt      <= '0;
          cdcReady <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A decoded answer in the final cycle still beats the timeout.
          if (cdcDecValid) begin
            respData     <= cdcDecData;
            respMismatch <= (cdcDecData != cdcData);
            respTimeout  <= 1'b0;
            respValid    <= grant_onehot;
            cdcReady     <= 1'b0;
            state        <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            respData     <= '0;
            respMismatch <= 1'b0;
            respTimeout  <= 1'b1;
            respValid    <= grant_onehot;
            cdcReady     <= 1'b0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (respReady[grant_reg]) begin
            respValid    <= '0;
            respData     <= '0;
            respMismatch <= 1'b0;
            respTimeout  <= 1'b0;
            cdcData      <= '0;
            cdcError     <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_codec_arbiter.sv
// Directed bench for hamming_codec_arbiter: the bench plays both requesters
// and the codec, with hand-computed expected responses.
module tb_hamming_codec_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic [1:0]  reqValid;
  logic [31:0] reqData;
  logic [41:0] reqError;
  logic [1:0]  reqReady;
  logic [1:0]  respValid;
  logic [1:0]  respReady;
  logic [15:0] respData;
  logic        respMismatch;
  logic        respTimeout;
  logic [15:0] cdcData;
  logic [20:0] cdcError;
  logic        cdcValid;
  logic        cdcReady;
  logic        cdcDecValid;
  logic [15:0] cdcDecData;
  logic [7:0]  spuriousCnt;

  int vectors = 0;
  int errors  = 0;

  hamming_codec_arbiter #(
    .NUM_REQ (2),
    .DATA_W  (16),
    .CODE_W  (21),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reqValid     (reqValid),
    .reqData      (reqData),
    .reqError     (reqError),
    .reqReady     (reqReady),
    .respValid    (respValid),
    .respReady    (respReady),
    .respData     (respData),
    .respMismatch (respMismatch),
    .respTimeout  (respTimeout),
    .cdcData      (cdcData),
    .cdcError     (cdcError),
    .cdcValid     (cdcValid),
    .cdcReady     (cdcReady),
    .cdcDecValid  (cdcDecValid),
    .cdcDecData   (cdcDecData),
    .spuriousCnt  (spuriousCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge after
  // the response has been accepted.
  task automatic run_txn(
    input logic [1:0]  valid,
    input int          g,
    input logic [15:0] d0,
    input logic [15:0] d1,
    input logic [20:0] e0,
    input logic [20:0] e1,
    input int          ans_cyc,
    input logic [15:0] ans,
    input logic [15:0] exp_data,
    input logic        exp_mm,
    input logic        exp_to,
    input logic        hold
  );
    int          c;
    int          exp_wait;
    logic [1:0]  oh;
    logic [15:0] dg;
    logic [20:0] eg;
    oh = 2'b01 << g;
    dg = (g != 0) ? d1 : d0;
    eg = (g != 0) ? e1 : e0;
    reqValid = valid;
    reqData  = {d1, d0};
    reqError = {e1, e0};
    #1;
    chk("req_ready", 32'(reqReady), 32'(oh));
    @(posedge clk);
    @(negedge clk);
    if (!hold) reqValid = 2'b00;
    #1;
    chk("cdc_valid", 32'(cdcValid), 32'd1);
    chk("cdc_data", 32'(cdcData), 32'(dg));
    chk("cdc_error", 32'(cdcError), 32'(eg));
    chk("req_ready_busy", 32'(reqReady), 32'd0);
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      cdcDecValid = 1'b0;
      #1;
      if (respValid != 2'b00) break;
      if (c == 0) begin
        chk("cdc_ready", 32'(cdcReady), 32'd1);
        chk("cdc_valid_pulse", 32'(cdcValid), 32'd0);
      end
      if (c == ans_cyc) begin
        cdcDecValid = 1'b1;
        cdcDecData  = ans;
      end
    end
    exp_wait = (ans_cyc >= 0 && ans_cyc < TIMEOUT) ? ans_cyc + 1 : TIMEOUT;
    chk("wait_cycles", 32'(c), 32'(exp_wait));
    chk("resp_valid", 32'(respValid), 32'(oh));
    chk("resp_data", 32'(respData), 32'(exp_data));
    chk("resp_mismatch", 32'(respMismatch), 32'(exp_mm));
    chk("resp_timeout", 32'(respTimeout), 32'(exp_to));
    respReady = ~oh;
    @(negedge clk);
    #1;
    chk("resp_hold", 32'(respValid), 32'(oh));
    respReady = oh;
    @(negedge clk);
    respReady = 2'b00;
    #1;
    chk("resp_done", 32'(respValid), 32'd0);
    chk("cdc_data_idle", 32'(cdcData), 32'd0);
    $display("txn grant=%0d data=%h err=%h resp=%h mm=%0d to=%0d wait=%0d",
             g, dg, eg, exp_data, exp_mm, exp_to, c);
  endtask

  initial begin
    rst         = 1'b0;
    reqValid    = '0;
    reqData     = '0;
    reqError    = '0;
    respReady   = '0;
    cdcDecValid = 1'b0;
    cdcDecData  = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(respValid), 32'd0);
    chk("rst_cdc_valid", 32'(cdcValid), 32'd0);
    chk("rst_cdc_ready", 32'(cdcReady), 32'd0);
    chk("rst_spurious", 32'(spuriousCnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Plain, correctable and uncorrectable transactions.
    run_txn(2'b01, 0, 16'h443D, 16'h0000, 21'd0, 21'd0, 2, 16'h443D, 16'h443D, 1'b0, 1'b0, 1'b0);
    run_txn(2'b10, 1, 16'h0000, 16'h443D, 21'd0, 21'd32, 2, 16'h443D, 16'h443D, 1'b0, 1'b0, 1'b0);
    run_txn(2'b10, 1, 16'h0000, 16'h443D, 21'd0, 21'h000021, 1, 16'h443C, 16'h443C, 1'b1, 1'b0, 1'b0);

    // Fairness with both requesters held valid: pointer is at 0 here.
    for (int i = 0; i < 6; i++) begin
      run_txn(2'b11, i % 2, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 21'h1, 21'h2, 0,
              (i % 2 != 0) ? 16'h2000 + 16'(i) : 16'h1000 + 16'(i),
              (i % 2 != 0) ? 16'h2000 + 16'(i) : 16'h1000 + 16'(i),
              1'b0, 1'b0, 1'b1);
    end
    reqValid = 2'b00;

    // Codec silent: timeout, then an answer coinciding with the timeout cycle.
    run_txn(2'b01, 0, 16'hA5A5, 16'h0000, 21'h1, 21'd0, -1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_txn(2'b01, 0, 16'h5A5A, 16'h0000, 21'd0, 21'd0, TIMEOUT - 1, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    chk("spurious_none", 32'(spuriousCnt), 32'd0);

    repeat (3) begin
      @(negedge clk);
      cdcDecValid = 1'b1;
      cdcDecData  = 16'hDEAD;
      @(negedge clk);
      cdcDecValid = 1'b0;
    end
    #1;
    chk("spurious_three", 32'(spuriousCnt), 32'd3);
    chk("spurious_no_resp", 32'(respValid), 32'd0);
    $display("txn spurious pulses=3 count=%0d", spuriousCnt);

    // Reset in the middle of WAIT with the pointer sitting at 1.
    reqData  = {16'hC0DE, 16'h0000};
    reqError = {21'h4, 21'h0};
    reqValid = 2'b10;
    @(posedge clk);
    @(negedge clk);
    reqValid = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_cdc_ready", 32'(cdcReady), 32'd1);
    chk("pre_rst_cdc_data", 32'(cdcData), 32'hC0DE);
    rst = 1'b1;
    #1;
    chk("mid_rst_cdc_ready", 32'(cdcReady), 32'd0);
    chk("mid_rst_cdc_data", 32'(cdcData), 32'd0);
    chk("mid_rst_cdc_error", 32'(cdcError), 32'd0);
    chk("mid_rst_spurious", 32'(spuriousCnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_no_resp", 32'(respValid), 32'd0);
    $display("txn reset mid-wait");
    run_txn(2'b11, 0, 16'h0F0F, 16'hF0F0, 21'd0, 21'd0, 0, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
